// File: rtl/host_bfm_types_pkg.sv
// Shared types for the host BFM: PCIe request tag type and tag-scheduler state encoding.
package host_bfm_types_pkg;
  localparam int TAG_W    = 10;
  localparam int MAX_TAGS = 1024;

  typedef logic [TAG_W-1:0] packet_tag_t;

  typedef enum logic {TS_INIT, TS_RUN} tag_sched_state_e;
endpackage

// File: rtl/host_bfm_tag_scheduler_if.sv
// Request/grant and completion bus between BFM request generators and the tag scheduler.
interface host_bfm_tag_scheduler_if #(parameter int NUM_REQ = 4);
  import host_bfm_types_pkg::*;

  logic [NUM_REQ-1:0] req;
  logic [NUM_REQ-1:0] gnt;
  packet_tag_t        gnt_tag;
  logic               cpl_valid;
  packet_tag_t        cpl_tag;
  logic               cpl_last;

  modport master (output req, cpl_valid, cpl_tag, cpl_last, input gnt, gnt_tag);
  modport slave  (input req, cpl_valid, cpl_tag, cpl_last, output gnt, gnt_tag);
endinterface

// File: rtl/host_bfm_tag_fifo.sv
// Free-tag FIFO: show-ahead head, same-cycle push+pop, pointers wrap at an arbitrary DEPTH.
module host_bfm_tag_fifo
  import host_bfm_types_pkg::*;
#(
  parameter  int DEPTH = 256,
  localparam int CNT_W = $clog2(DEPTH+1),
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  packet_tag_t      push_data,
  input  logic             pop,
  output packet_tag_t      head,
  output logic             empty,
  output logic [CNT_W-1:0] count
);
  packet_tag_t      mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH-1)) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // a full FIFO still accepts a push when the same cycle pops
  assign do_push = push && ((count != CNT_W'(DEPTH)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk)
    if (do_push) mem[wr_ptr] <= push_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= bump(wr_ptr);
      if (do_pop)  rd_ptr <= bump(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end
endmodule

// File: rtl/host_bfm_tag_scheduler.sv
// Round-robin requester arbiter that binds a free PCIe tag to each grant and
// recycles tags on their final completion.
module host_bfm_tag_scheduler
  import host_bfm_types_pkg::*;
#(
  parameter  int NUM_REQ   = 4,
  parameter  int TAG_COUNT = 256,
  localparam int CNT_W     = $clog2(TAG_COUNT+1)
) (
  input  logic                      clk,
  input  logic                      rst,
  host_bfm_tag_scheduler_if.slave   bus,
  output logic                      init_done,
  output logic [CNT_W-1:0]          outstanding,
  output logic                      err_free_unused,
  output logic                      err_tag_range
);
  localparam int RR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  tag_sched_state_e     state, state_nxt;
  packet_tag_t          init_cnt;
  logic [RR_W-1:0]      rr_ptr, winner;
  logic                 found;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   rot;
  logic [TAG_COUNT-1:0] in_use, in_use_nxt;
  logic                 grant, rel_try, in_range, cpl_used, rel_ok;
  logic                 fifo_push;
  packet_tag_t          fifo_data, head;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  host_bfm_tag_fifo #(.DEPTH(TAG_COUNT)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_data),
    .pop       (grant),
    .head      (head),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // rotate requests so bit 0 is rr_ptr; the lowest set bit is the winner offset
  always_comb begin
    req_dbl = {bus.req, bus.req} >> rr_ptr;
    rot     = req_dbl[NUM_REQ-1:0];
    found   = 1'b0;
    winner  = rr_ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!found && rot[k]) begin
        found  = 1'b1;
        winner = (int'(rr_ptr) + k >= NUM_REQ) ? RR_W'(int'(rr_ptr) + k - NUM_REQ)
                                               : RR_W'(int'(rr_ptr) + k);
      end
    end
  end

  assign in_range = int'(bus.cpl_tag) < TAG_COUNT;
  assign rel_try  = bus.cpl_valid && bus.cpl_last && (state == TS_RUN);
  // bitmap is read pre-grant, so releasing the tag granted this cycle counts as unused
  assign rel_ok   = rel_try && in_range && cpl_used;

  always_comb begin
    cpl_used = 1'b0;
    for (int t = 0; t < TAG_COUNT; t++)
      if (bus.cpl_tag == packet_tag_t'(t)) cpl_used = in_use[t];
  end

  always_comb begin
    in_use_nxt = in_use;
    for (int t = 0; t < TAG_COUNT; t++) begin
      if (grant && head == packet_tag_t'(t))           in_use_nxt[t] = 1'b1;
      if (rel_ok && bus.cpl_tag == packet_tag_t'(t))   in_use_nxt[t] = 1'b0;
    end
  end

  always_comb begin
    state_nxt = state;
    grant     = 1'b0;
    fifo_push = 1'b0;
    fifo_data = bus.cpl_tag;
    case (state)
      TS_INIT: begin
        fifo_push = 1'b1;
        fifo_data = init_cnt;
        if (init_cnt == packet_tag_t'(TAG_COUNT-1)) state_nxt = TS_RUN;
      end
      TS_RUN: begin
        grant     = found && !fifo_empty;
        fifo_push = rel_ok;
      end
      default: state_nxt = TS_INIT;
    endcase
  end

  always_comb begin
    bus.gnt = '0;
    for (int i = 0; i < NUM_REQ; i++)
      bus.gnt[i] = grant && (winner == RR_W'(i));
  end

  assign bus.gnt_tag = head;
  assign init_done   = (state == TS_RUN);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= TS_INIT;
      init_cnt        <= '0;
      rr_ptr          <= '0;
      in_use          <= '0;
      outstanding     <= '0;
      err_free_unused <= 1'b0;
      err_tag_range   <= 1'b0;
    end else begin
      state  <= state_nxt;
      in_use <= in_use_nxt;
      if (state == TS_INIT) init_cnt <= init_cnt + 1'b1;
      if (grant) rr_ptr <= (winner == RR_W'(NUM_REQ-1)) ? '0 : winner + 1'b1;
      if (grant && !rel_ok)      outstanding <= outstanding + 1'b1;
      else if (rel_ok && !grant) outstanding <= outstanding - 1'b1;
      if (bus.cpl_valid && !in_range) err_tag_range <= 1'b1;
      if ((rel_try && in_range && !cpl_used) ||
          (state == TS_INIT && bus.cpl_valid && bus.cpl_last))
        err_free_unused <= 1'b1;
    end
  end

  a_pool_conserved: assert property (@(posedge clk) disable iff (rst)
    (state == TS_RUN) |-> (int'(outstanding) + int'(fifo_count) == TAG_COUNT));
endmodule

// File: tb/tb_host_bfm_tag_scheduler.sv
// Bench for host_bfm_tag_scheduler: directed scenarios plus random traffic against a queue-based pool model.
module tb_host_bfm_tag_scheduler;
  import host_bfm_types_pkg::*;

  localparam int NR = 4;
  localparam int TC = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       init_done, err_free_unused, err_tag_range;
  logic [3:0] outstanding;

  host_bfm_tag_scheduler_if #(.NUM_REQ(NR)) bus ();

  host_bfm_tag_scheduler #(.NUM_REQ(NR), .TAG_COUNT(TC)) dut (
    .clk             (clk),
    .rst             (rst),
    .bus             (bus),
    .init_done       (init_done),
    .outstanding     (outstanding),
    .err_free_unused (err_free_unused),
    .err_tag_range   (err_tag_range)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // pool model: free tags in FIFO order, in-use set, rr pointer, counters
  int  free_q[$];
  bit  m_used[TC];
  int  m_rr, m_out, m_icnt;
  bit  m_run, m_efu, m_etr;

  logic [NR-1:0] exp_gnt, got_gnt;
  int            exp_tag, exp_win;
  packet_tag_t   got_tag;

  task automatic model_reset();
    free_q.delete();
    foreach (m_used[t]) m_used[t] = 1'b0;
    m_rr = 0; m_out = 0; m_icnt = 0;
    m_run = 1'b0; m_efu = 1'b0; m_etr = 1'b0;
  endtask

  task automatic model_expect(input logic [NR-1:0] r);
    exp_gnt = '0; exp_tag = 0; exp_win = -1;
    if (m_run && r != '0 && free_q.size() > 0)
      for (int i = 0; i < NR; i++) begin
        int w;
        w = (m_rr + i) % NR;
        if (exp_win < 0 && r[w]) exp_win = w;
      end
    if (exp_win >= 0) begin
      exp_gnt[exp_win] = 1'b1;
      exp_tag = free_q[0];
    end
  endtask

  task automatic model_update(input logic cv, input int ct, input logic cl);
    bit rel_ok;
    rel_ok = 1'b0;
    if (!m_run) begin
      free_q.push_back(m_icnt);
      m_icnt++;
      if (cv && cl) m_efu = 1'b1;
      if (cv && ct >= TC) m_etr = 1'b1;
      if (m_icnt == TC) m_run = 1'b1;
    end else begin
      if (cv && ct >= TC) m_etr = 1'b1;
      else if (cv && cl) begin
        if (m_used[ct]) rel_ok = 1'b1;
        else m_efu = 1'b1;
      end
      if (exp_win >= 0) begin
        void'(free_q.pop_front());
        m_used[exp_tag] = 1'b1;
        m_out++;
        m_rr = (exp_win + 1) % NR;
      end
      if (rel_ok) begin
        m_used[ct] = 1'b0;
        free_q.push_back(ct);
        m_out--;
      end
    end
  endtask

  // drive at negedge, sample combinational grant, advance model at posedge, return at posedge+1
  task automatic step(input logic [NR-1:0] r, input logic cv, input int ct, input logic cl);
    @(negedge clk);
    bus.req = r; bus.cpl_valid = cv; bus.cpl_tag = packet_tag_t'(ct); bus.cpl_last = cl;
    #1;
    got_gnt = bus.gnt; got_tag = bus.gnt_tag;
    model_expect(r);
    @(posedge clk);
    model_update(cv, ct, cl);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #1;
    model_reset();
  endtask

  task automatic release_reset();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_reset();
    bus.req = '0; bus.cpl_valid = 1'b0; bus.cpl_tag = '0; bus.cpl_last = 1'b0;
    do_reset();
    checks++; if (bus.gnt !== 4'b0) $display("FAIL rst_gnt: got %b want 0", bus.gnt); else passes++;
    checks++; if (init_done !== 1'b0) $display("FAIL rst_init_done: got %b want 0", init_done); else passes++;
    checks++; if (outstanding !== 4'd0) $display("FAIL rst_outstanding: got %0d want 0", outstanding); else passes++;
    checks++; if ({err_free_unused, err_tag_range} !== 2'b00)
      $display("FAIL rst_errs: got %b want 00", {err_free_unused, err_tag_range}); else passes++;
    release_reset();
    for (int k = 0; k < TC; k++) begin
      step('0, 1'b0, 0, 1'b0);
      checks++; if (init_done !== (k == TC-1))
        $display("FAIL init_done_cycle%0d: got %b want %b", k, init_done, (k == TC-1)); else passes++;
    end
    checks++; if (outstanding !== 4'd0) $display("FAIL init_outstanding: got %0d want 0", outstanding); else passes++;
  endtask

  task automatic test_rr_exhaust();
    for (int k = 0; k < TC; k++) begin
      step(4'b1111, 1'b0, 0, 1'b0);
      checks++; if (got_gnt !== 4'(1 << (k % NR)) || got_gnt !== exp_gnt)
        $display("FAIL rr_gnt%0d: got %b want %b", k, got_gnt, 4'(1 << (k % NR))); else passes++;
      checks++; if (got_tag !== packet_tag_t'(k))
        $display("FAIL rr_tag%0d: got %0d want %0d", k, got_tag, k); else passes++;
    end
    checks++; if (outstanding !== 4'd8) $display("FAIL rr_outstanding: got %0d want 8", outstanding); else passes++;
    step(4'b1111, 1'b0, 0, 1'b0);
    checks++; if (got_gnt !== 4'b0) $display("FAIL empty_gnt: got %b want 0", got_gnt); else passes++;
  endtask

  task automatic test_release_regrant();
    step(4'b1111, 1'b1, 5, 1'b1);
    checks++; if (got_gnt !== 4'b0) $display("FAIL rel_gnt_empty: got %b want 0", got_gnt); else passes++;
    checks++; if (outstanding !== 4'd7) $display("FAIL rel_out7: got %0d want 7", outstanding); else passes++;
    step(4'b1111, 1'b0, 0, 1'b0);
    checks++; if (got_gnt !== 4'b0001 || got_tag !== packet_tag_t'(5))
      $display("FAIL regrant: got gnt %b tag %0d want 0001 tag 5", got_gnt, got_tag); else passes++;
    checks++; if (outstanding !== 4'd8) $display("FAIL regrant_out8: got %0d want 8", outstanding); else passes++;
  endtask

  task automatic test_same_cycle();
    step('0, 1'b1, 1, 1'b1);
    step('0, 1'b1, 2, 1'b1);
    checks++; if (outstanding !== 4'd6) $display("FAIL sc_out6: got %0d want 6", outstanding); else passes++;
    step(4'b0010, 1'b1, 3, 1'b1);
    checks++; if (got_gnt !== 4'b0010 || got_tag !== packet_tag_t'(1))
      $display("FAIL sc_gnt: got gnt %b tag %0d want 0010 tag 1", got_gnt, got_tag); else passes++;
    checks++; if (outstanding !== 4'd6) $display("FAIL sc_out_hold: got %0d want 6", outstanding); else passes++;
    step(4'b1111, 1'b0, 0, 1'b0);
    checks++; if (got_gnt !== 4'b0100 || got_tag !== packet_tag_t'(2))
      $display("FAIL sc_order2: got gnt %b tag %0d want 0100 tag 2", got_gnt, got_tag); else passes++;
    step(4'b1111, 1'b0, 0, 1'b0);
    checks++; if (got_gnt !== 4'b1000 || got_tag !== packet_tag_t'(3))
      $display("FAIL sc_order3: got gnt %b tag %0d want 1000 tag 3", got_gnt, got_tag); else passes++;
  endtask

  task automatic test_errors();
    step('0, 1'b1, 6, 1'b1);
    checks++; if (err_free_unused !== 1'b0 || outstanding !== 4'd7)
      $display("FAIL err_first_free: got efu %b out %0d want 0 7", err_free_unused, outstanding); else passes++;
    step('0, 1'b1, 6, 1'b1);
    checks++; if (err_free_unused !== 1'b1 || outstanding !== 4'd7)
      $display("FAIL err_double_free: got efu %b out %0d want 1 7", err_free_unused, outstanding); else passes++;
    step('0, 1'b1, 4, 1'b0);
    checks++; if (outstanding !== 4'd7) $display("FAIL nonlast_cpl: got %0d want 7", outstanding); else passes++;
    checks++; if (err_tag_range !== 1'b0) $display("FAIL etr_early: got %b want 0", err_tag_range); else passes++;
    step('0, 1'b1, 9, 1'b1);
    checks++; if (err_tag_range !== 1'b1 || outstanding !== 4'd7)
      $display("FAIL err_range: got etr %b out %0d want 1 7", err_tag_range, outstanding); else passes++;
    step(4'b0001, 1'b1, 6, 1'b1);
    checks++; if (got_tag !== packet_tag_t'(6) || outstanding !== 4'd8)
      $display("FAIL grant_self_release: got tag %0d out %0d want 6 8", got_tag, outstanding); else passes++;
  endtask

  task automatic test_random();
    logic [NR-1:0] r;
    logic          cv, cl;
    int            ct;
    int            ul[$];
    for (int n = 0; n < 300; n++) begin
      r  = 4'($urandom_range(0, 15));
      cv = 1'($urandom_range(0, 1));
      cl = ($urandom_range(0, 3) != 0);
      ul.delete();
      for (int t = 0; t < TC; t++) if (m_used[t]) ul.push_back(t);
      if ($urandom_range(0, 9) < 8 && ul.size() > 0) ct = ul[$urandom_range(0, ul.size()-1)];
      else ct = int'($urandom_range(0, 9));
      step(r, cv, ct, cl);
      checks++; if (got_gnt !== exp_gnt)
        $display("FAIL rand_gnt%0d: got %b want %b", n, got_gnt, exp_gnt); else passes++;
      if (exp_gnt != '0) begin
        checks++; if (got_tag !== packet_tag_t'(exp_tag))
          $display("FAIL rand_tag%0d: got %0d want %0d", n, got_tag, exp_tag); else passes++;
      end
      checks++; if (outstanding !== 4'(m_out))
        $display("FAIL rand_out%0d: got %0d want %0d", n, outstanding, m_out); else passes++;
      checks++; if ({err_free_unused, err_tag_range} !== {m_efu, m_etr})
        $display("FAIL rand_errs%0d: got %b want %b", n, {err_free_unused, err_tag_range}, {m_efu, m_etr}); else passes++;
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    release_reset();
    repeat (TC) step('0, 1'b0, 0, 1'b0);
    repeat (5) step(4'b1111, 1'b0, 0, 1'b0);
    checks++; if (outstanding !== 4'd5) $display("FAIL mr_out5: got %0d want 5", outstanding); else passes++;
    step('0, 1'b1, 9, 1'b1);
    bus.req = 4'b1111; bus.cpl_valid = 1'b0;
    do_reset();
    checks++; if (bus.gnt !== 4'b0 || init_done !== 1'b0 || outstanding !== 4'd0)
      $display("FAIL mr_outputs: got gnt %b done %b out %0d want 0 0 0", bus.gnt, init_done, outstanding); else passes++;
    checks++; if ({err_free_unused, err_tag_range} !== 2'b00)
      $display("FAIL mr_errs: got %b want 00", {err_free_unused, err_tag_range}); else passes++;
    release_reset();
    for (int k = 0; k < TC; k++) begin
      step(4'b1111, 1'b0, 0, 1'b0);
      checks++; if (got_gnt !== 4'b0) $display("FAIL mr_init_gnt%0d: got %b want 0", k, got_gnt); else passes++;
    end
    step(4'b1111, 1'b0, 0, 1'b0);
    checks++; if (got_gnt !== 4'b0001 || got_tag !== packet_tag_t'(0))
      $display("FAIL mr_restart: got gnt %b tag %0d want 0001 tag 0", got_gnt, got_tag); else passes++;
  endtask

  initial begin
    test_reset();
    test_rr_exhaust();
    test_release_regrant();
    test_same_cycle();
    test_errors();
    test_random();
    test_mid_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
